// File: rtl/ca_pkg.sv
// Shared types and sizing helpers for the cellular-automaton rule engine.
package ca_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Neighbourhood size for a given radius.
  function automatic int k_of(input int radius);
    return 2 * radius + 1;
  endfunction

  // Rule table size: one output bit per neighbourhood pattern.
  function automatic int tbl_of(input int radius);
    return 1 << k_of(radius);
  endfunction

endpackage

// File: rtl/ca_next_gen.sv
// Combinational next-generation function: applies the rule to every cell at once.
module ca_next_gen
  import ca_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int RADIUS = 1
) (
  input  logic [WIDTH-1:0]          state,
  input  logic [tbl_of(RADIUS)-1:0] rule,
  input  logic                      wrap,
  output logic [WIDTH-1:0]          next_state
);

  localparam int K   = k_of(RADIUS);
  localparam int TBL = tbl_of(RADIUS);

  // The rule is stored MSB-first, so flip it once to index it directly by pattern.
  logic [TBL-1:0] rule_rev;

  for (genvar n = 0; n < TBL; n++) begin : g_rev
    assign rule_rev[n] = rule[TBL-1-n];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic [K-1:0] nb;

    // Tap j=0 is the leftmost (highest-index) neighbour and lands in the MSB.
    for (genvar j = 0; j < K; j++) begin : g_tap
      localparam int POS  = i + RADIUS - j;
      localparam int MODP = ((POS % WIDTH) + WIDTH) % WIDTH;
      if (POS >= 0 && POS < WIDTH) begin : g_in
        assign nb[K-1-j] = state[POS];
      end else begin : g_edge
        assign nb[K-1-j] = wrap & state[MODP];
      end
    end

    assign next_state[i] = rule_rev[nb];
  end

endmodule

// File: rtl/ca_rule_engine.sv
// Run-time loadable elementary CA engine: iterates a rule for a configured
// number of generations and streams each one over a valid/ready handshake.
module ca_rule_engine
  import ca_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int RADIUS = 1,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [tbl_of(RADIUS)-1:0] cfg_rule,
  input  logic [WIDTH-1:0]          cfg_seed,
  input  logic [CNT_W-1:0]          cfg_steps,
  input  logic                      cfg_wrap,
  input  logic                      abort,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_state,
  output logic [CNT_W-1:0]          out_gen,
  output logic                      out_last,
  output logic                      busy
);

  localparam int TBL = tbl_of(RADIUS);

  state_t           state, state_nx;
  logic [TBL-1:0]   rule_q;
  logic [CNT_W-1:0] steps_q;
  logic             wrap_q;
  logic [WIDTH-1:0] next_state;
  logic [CNT_W-1:0] gen_inc;
  logic             accept, advance;

  ca_next_gen #(
    .WIDTH (WIDTH),
    .RADIUS(RADIUS)
  ) u_next_gen (
    .state     (out_state),
    .rule      (rule_q),
    .wrap      (wrap_q),
    .next_state(next_state)
  );

  assign gen_inc   = out_gen + 1'b1;
  assign busy      = (state == RUN);
  assign cfg_ready = (state == IDLE);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    advance  = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_valid) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        // abort wins over a handshake landing in the same cycle.
        if (abort) begin
          state_nx = IDLE;
        end else if (out_valid && out_ready) begin
          if (out_last) state_nx = IDLE;
          else          advance  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rule_q    <= '0;
      steps_q   <= '0;
      wrap_q    <= 1'b0;
      out_state <= '0;
      out_gen   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= (state_nx == RUN);
      if (accept) begin
        rule_q    <= cfg_rule;
        steps_q   <= cfg_steps;
        wrap_q    <= cfg_wrap;
        out_state <= cfg_seed;
        out_gen   <= '0;
        out_last  <= (cfg_steps == '0);
      end else if (advance) begin
        // gen never exceeds steps, so gen_inc cannot overflow here.
        out_state <= next_state;
        out_gen   <= gen_inc;
        out_last  <= (gen_inc == steps_q);
      end
    end
  end

endmodule

// File: tb/tb_ca_rule_engine.sv
// Self-checking bench for ca_rule_engine: directed scenarios plus randomized
// runs, all compared every cycle against a generation-level reference model.
module tb_ca_rule_engine;

  localparam int W = 8;
  localparam int R = 1;
  localparam int T = 8;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [T-1:0] cfg_rule = '0;
  logic [W-1:0] cfg_seed = '0;
  logic [C-1:0] cfg_steps = '0;
  logic         cfg_wrap = 1'b0;
  logic         abort = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_state;
  logic [C-1:0] out_gen;
  logic         out_last;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  ca_rule_engine #(.WIDTH(W), .RADIUS(R), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_rule(cfg_rule), .cfg_seed(cfg_seed), .cfg_steps(cfg_steps),
    .cfg_wrap(cfg_wrap), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .out_state(out_state), .out_gen(out_gen),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference rule application straight from the cell definition.
  function automatic logic [W-1:0] ca_step(input logic [W-1:0] s, input logic [T-1:0] rule,
                                           input bit wrap);
    logic [W-1:0] n;
    n = '0;
    for (int i = 0; i < W; i++) begin
      int idx;
      idx = 0;
      for (int d = R; d >= -R; d--) begin
        int p;
        int b;
        p = i + d;
        if (wrap) p = ((p % W) + W) % W;
        b = (p >= 0 && p < W) ? int'(s[p]) : 0;
        idx = idx * 2 + b;
      end
      n[i] = rule[T-1-idx];
    end
    return n;
  endfunction

  // Generation-level model: which generation of which run is on display.
  bit           m_run = 0;
  logic [T-1:0] m_rule = '0;
  logic [C-1:0] m_steps = '0;
  bit           m_wrap = 0;
  logic [W-1:0] m_state = '0;
  int           m_gen = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_rule = '0; m_steps = '0; m_wrap = 0; m_state = '0; m_gen = 0;
    end else if (!m_run) begin
      if (cfg_valid) begin
        m_run = 1; m_rule = cfg_rule; m_steps = cfg_steps; m_wrap = cfg_wrap;
        m_state = cfg_seed; m_gen = 0;
      end
    end else if (abort) begin
      m_run = 0;
    end else if (out_ready) begin
      if (m_gen == int'(m_steps)) m_run = 0;
      else begin
        m_state = ca_step(m_state, m_rule, m_wrap);
        m_gen++;
      end
    end
  end

  always @(negedge clk) begin
    check("out_valid", 32'(out_valid), 32'(m_run));
    check("busy", 32'(busy), 32'(m_run));
    check("cfg_ready", 32'(cfg_ready), 32'(!m_run));
    check("out_state", 32'(out_state), 32'(m_state));
    check("out_gen", 32'(out_gen), 32'(m_gen));
    if (m_run) check("out_last", 32'(out_last), 32'(m_gen == int'(m_steps)));
  end

  typedef struct {
    logic [W-1:0] s;
    logic [C-1:0] g;
    logic         l;
  } beat_t;
  beat_t beats[$];

  always @(negedge clk) begin
    if (out_valid && out_ready && !abort && !rst)
      beats.push_back('{s: out_state, g: out_gen, l: out_last});
  end

  // Called at posedge+1 while idle; returns at posedge+1 after the accept edge.
  task automatic drive_cfg(input logic [T-1:0] rule, input logic [W-1:0] seed,
                           input logic [C-1:0] steps, input bit wrap);
    cfg_rule = rule; cfg_seed = seed; cfg_steps = steps; cfg_wrap = wrap;
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_within_budget", 32'(busy), 32'(0));
  endtask

  task automatic check_beat(input string name, input int k, input logic [W-1:0] s,
                            input logic [C-1:0] g, input logic l);
    if (k < beats.size()) begin
      check({name, "_state"}, 32'(beats[k].s), 32'(s));
      check({name, "_gen"}, 32'(beats[k].g), 32'(g));
      check({name, "_last"}, 32'(beats[k].l), 32'(l));
    end else begin
      check({name, "_present"}, 32'(beats.size()), 32'(k + 1));
    end
  endtask

  task automatic scenario1(input string tag);
    beats.delete();
    out_ready = 1'b1;
    drive_cfg(8'h4E, 8'h10, 8'd1, 1'b1);
    wait_idle(20);
    check({tag, "_beats"}, 32'(beats.size()), 32'd2);
    check_beat({tag, "_b0"}, 0, 8'h10, 8'd0, 1'b0);
    check_beat({tag, "_b1"}, 1, 8'h28, 8'd1, 1'b1);
    check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
  endtask

  initial begin
    int n;

    // Pin the model against hand-derived generations.
    check("model_r4e_wrap", 32'(ca_step(8'h10, 8'h4E, 1'b1)), 32'h28);
    check("model_edge_nowrap", 32'(ca_step(8'h80, 8'h4E, 1'b0)), 32'h40);
    check("model_edge_wrap", 32'(ca_step(8'h80, 8'h4E, 1'b1)), 32'h41);

    #2 rst = 1'b1;
    #10 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_state", 32'(out_state), 32'd0);
    check("rst_out_gen", 32'(out_gen), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);

    // 1: basic run.
    scenario1("s1");

    // 2: boundary handling.
    beats.delete();
    drive_cfg(8'h4E, 8'h80, 8'd1, 1'b0);
    wait_idle(20);
    check_beat("s2_nowrap", 1, 8'h40, 8'd1, 1'b1);
    beats.delete();
    drive_cfg(8'h4E, 8'h80, 8'd1, 1'b1);
    wait_idle(20);
    check_beat("s2_wrap", 1, 8'h41, 8'd1, 1'b1);

    // 3: backpressure during gen1.
    beats.delete();
    drive_cfg(8'h1E, 8'h08, 8'd3, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("s3_stall_gen", 32'(out_gen), 32'd1);
      check("s3_stall_state", 32'(out_state), 32'(ca_step(8'h08, 8'h1E, 1'b1)));
    end
    out_ready = 1'b1;
    wait_idle(20);
    check("s3_beats", 32'(beats.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      check_beat("s3", k, beats.size() > k ? beats[k].s : '0, C'(k), k == 3);

    // 4: steps=0 with cfg_valid held through the run.
    beats.delete();
    out_ready = 1'b0;
    cfg_rule = 8'h5A; cfg_seed = 8'hA5; cfg_steps = 8'd0; cfg_wrap = 1'b0;
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_seed = 8'h3C; cfg_steps = 8'd4;
    repeat (2) @(posedge clk);
    #1;
    check("s4_state_held", 32'(out_state), 32'hA5);
    check("s4_gen_held", 32'(out_gen), 32'd0);
    check("s4_last", 32'(out_last), 32'd1);
    cfg_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("s4_done", 32'(busy), 32'd0);
    check("s4_beats", 32'(beats.size()), 32'd1);
    check_beat("s4_b0", 0, 8'hA5, 8'd0, 1'b1);

    // 5: abort during gen2, then accept a config with abort still high.
    beats.delete();
    drive_cfg(8'h6E, 8'h01, 8'd5, 1'b1);
    n = 0;
    while (out_gen != 8'd2 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("s5_reached_gen2", 32'(out_gen), 32'd2);
    abort = 1'b1;
    @(posedge clk); #1;
    check("s5_abort_valid", 32'(out_valid), 32'd0);
    check("s5_abort_busy", 32'(busy), 32'd0);
    check("s5_abort_gen_kept", 32'(out_gen), 32'd2);
    check("s5_beats", 32'(beats.size()), 32'd2);
    drive_cfg(8'h4E, 8'h10, 8'd1, 1'b1);
    abort = 1'b0;
    check("s5_reaccept_busy", 32'(busy), 32'd1);
    check("s5_reaccept_state", 32'(out_state), 32'h10);
    wait_idle(20);

    // 6: asynchronous reset between edges, then repeat scenario 1.
    out_ready = 1'b0;
    drive_cfg(8'h4E, 8'h10, 8'd1, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("s6_rst_valid", 32'(out_valid), 32'd0);
    check("s6_rst_busy", 32'(busy), 32'd0);
    check("s6_rst_state", 32'(out_state), 32'd0);
    check("s6_rst_ready", 32'(cfg_ready), 32'd1);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    scenario1("s6");

    // Randomized runs with random backpressure, aborts and ignored configs.
    for (int run = 0; run < 60; run++) begin
      out_ready = 1'b1;
      abort = 1'b0;
      drive_cfg(T'($urandom), W'($urandom), C'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
      for (int c = 0; c < 300; c++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        abort = ($urandom_range(0, 24) == 0);
        cfg_valid = 1'($urandom_range(0, 1));
        cfg_seed = W'($urandom);
        @(posedge clk); #1;
        if (!busy) break;
      end
      cfg_valid = 1'b0;
      abort = 1'b0;
      check("rand_idle", 32'(busy), 32'd0);
    end

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
